// File: rtl/dmem_stage.sv
// dmem_stage: memory-access stage between execute and writeback.
// Runs one load/store at a time on a single-outstanding data bus.
// Ports: clk/rst; ex_* op from execute; mem_stall to upstream;
//   bus_* request/response; wb_* load result for one cycle;
//   misalign pulse when DMEM_MISALIGN_TRAP_EN is defined.
// DMEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses
//   instead of masking the address to natural alignment.
module dmem_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [RD_W-1:0] ex_rd,
  output logic            mem_stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_be,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            wb_load_active,
  output logic [RD_W-1:0] wb_next_rd,
  output logic [XLEN-1:0] wb_next_rd_value
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            w_is_load;
  logic            w_is_store;
  logic            w_legal;
  logic            w_memop;
  logic            w_mis;
  logic            w_accept;
  logic [1:0]      w_off;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_ext;

  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic            r_load;
  logic [RD_W-1:0] r_rd;
  logic            r_req;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_be;
  logic            r_wb_active;
  logic [RD_W-1:0] r_wb_rd;
  logic [XLEN-1:0] r_wb_value;

  // Load wins when both load and store are flagged.
  assign w_is_load  = ex_load;
  assign w_is_store = ex_store & ~ex_load;

  always_comb begin
    w_legal = 1'b0;
    if (w_is_load) begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101: w_legal = 1'b1;
        default:        w_legal = 1'b0;
      endcase
    end else if (w_is_store) begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010: w_legal = 1'b1;
        default:                w_legal = 1'b0;
      endcase
    end
  end

  assign w_memop = ex_valid & w_legal;

  // Byte offset inside the word, masked to natural alignment.
  always_comb begin
    w_off = 2'b00;
    case (ex_funct3[1:0])
      2'b00:   w_off = ex_addr[1:0];
      2'b01:   w_off = {ex_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    w_mis = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   w_mis = ex_addr[0];
      2'b10:   w_mis = |ex_addr[1:0];
      default: w_mis = 1'b0;
    endcase
  end
`else
  assign w_mis = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) & w_memop & ~w_mis;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (w_is_store) begin
      case (ex_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{ex_store_data[7:0]}};
        end
        2'b01: begin
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{ex_store_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ex_store_data;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_stall   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUS;
          mem_stall   = 1'b1;
        end
      end
      S_BUS: begin
        if (bus_ack) w_state_nxt = S_IDLE;
        else         mem_stall   = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_shift = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shift;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ext = {24'd0, w_shift[7:0]};
      3'b101:  w_ext = {16'd0, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct3    <= '0;
      r_off       <= '0;
      r_load      <= 1'b0;
      r_rd        <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_wb_active <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_value  <= '0;
    end else begin
      r_wb_active <= 1'b0;
      if (w_accept) begin
        r_funct3 <= ex_funct3;
        r_off    <= w_off;
        r_load   <= w_is_load;
        r_rd     <= ex_rd;
        r_req    <= 1'b1;
        r_we     <= w_is_store;
        r_addr   <= {ex_addr[XLEN-1:2], 2'b00};
        r_wdata  <= w_wdata;
        r_be     <= w_be;
      end else if ((r_state == S_BUS) && bus_ack) begin
        r_req <= 1'b0;
        if (r_load) begin
          r_wb_active <= 1'b1;
          r_wb_rd     <= r_rd;
          r_wb_value  <= (r_rd == '0) ? '0 : w_ext;
        end
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= (r_state == S_IDLE) & w_memop & w_mis;
  end

  assign misalign = r_misalign;
`endif

  assign bus_req          = r_req;
  assign bus_we           = r_we;
  assign bus_addr         = r_addr;
  assign bus_wdata        = r_wdata;
  assign bus_be           = r_be;
  assign wb_load_active   = r_wb_active;
  assign wb_next_rd       = r_wb_rd;
  assign wb_next_rd_value = r_wb_value;

endmodule
